// File: rtl/cart_loader_if.sv
// rtl/cart_loader_if.sv - ioctl download stream in, cartridge RAM write port out
interface cart_loader_if #(
    parameter int ADDR_W  = 15,
    parameter int REGIONS = 2
);
    localparam int RW = $clog2(REGIONS);

    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [RW-1:0]     mem_region;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  mem_we, mem_addr, mem_din, mem_region
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output mem_we, mem_addr, mem_din, mem_region
    );
endinterface

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - cartridge image loader from ioctl stream into per-region block RAMs
module cart_loader #(
    parameter int         ADDR_W     = 15,
    parameter int         REGIONS    = 2,
    parameter int         INDEX_BASE = 1,
    parameter int         CLEAR_FILL = 1,
    parameter logic [7:0] FILL_VALUE = 8'hFF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    cart_loader_if.slave         io,
    input  logic                 cart_eject,
    output logic [ADDR_W:0]      cart_size,
    output logic [REGIONS-1:0]   cart_loaded,
    output logic                 overflow,
    output logic                 busy
);
    localparam int RW = $clog2(REGIONS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE   = 1;

    logic [1:0]      state;
    logic            dl_q;
    logic [RW-1:0]   region;
    logic [ADDR_W:0] fill_ptr;

    logic            rise, fall, in_range, start_ok, addr_ok, accept;
    logic [RW-1:0]   new_region;
    logic [ADDR_W:0] wr_size, size_next;

    assign rise       = io.ioctl_download & ~dl_q;
    assign fall       = ~io.ioctl_download & dl_q;
    assign in_range   = ({1'b0, io.ioctl_index} >= 9'(INDEX_BASE)) &&
                        ({1'b0, io.ioctl_index} <  9'(INDEX_BASE + REGIONS));
    assign new_region = RW'(io.ioctl_index - 8'(INDEX_BASE));
    // A new in-range download may also preempt an unfinished fill.
    assign start_ok   = rise && in_range && (state == S_IDLE || state == S_FILL);

    assign addr_ok    = (io.ioctl_addr[24:ADDR_W] == '0);
    assign accept     = (state == S_LOAD) && io.ioctl_wr && addr_ok;
    assign wr_size    = {1'b0, io.ioctl_addr[ADDR_W-1:0]} + ONE;
    // Size seen by the fall decision includes a byte written on the fall cycle.
    assign size_next  = (accept && (wr_size > cart_size)) ? wr_size : cart_size;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            dl_q          <= 1'b0;
            region        <= '0;
            fill_ptr      <= '0;
            cart_size     <= '0;
            cart_loaded   <= '0;
            overflow      <= 1'b0;
            io.mem_we     <= 1'b0;
            io.mem_addr   <= '0;
            io.mem_din    <= '0;
            io.mem_region <= '0;
        end else begin
            dl_q      <= io.ioctl_download;
            io.mem_we <= 1'b0;
            if (cart_eject)
                cart_loaded <= '0;

            if (start_ok) begin
                state                   <= S_LOAD;
                region                  <= new_region;
                cart_size               <= '0;
                overflow                <= 1'b0;
                cart_loaded[new_region] <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (accept) begin
                            io.mem_we     <= 1'b1;
                            io.mem_addr   <= io.ioctl_addr[ADDR_W-1:0];
                            io.mem_din    <= io.ioctl_dout;
                            io.mem_region <= region;
                            cart_size     <= size_next;
                        end else if (io.ioctl_wr && !addr_ok) begin
                            overflow <= 1'b1;
                        end
                        if (fall) begin
                            if (CLEAR_FILL != 0 && size_next < DEPTH) begin
                                state    <= S_FILL;
                                fill_ptr <= size_next;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                    S_FILL: begin
                        io.mem_we     <= 1'b1;
                        io.mem_addr   <= fill_ptr[ADDR_W-1:0];
                        io.mem_din    <= FILL_VALUE;
                        io.mem_region <= region;
                        fill_ptr      <= fill_ptr + ONE;
                        if (fill_ptr == LAST)
                            state <= S_DONE;
                    end
                    S_DONE: begin
                        // Placed after the eject clear so DONE wins for its own region.
                        cart_loaded[region] <= (cart_size != '0);
                        state               <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - directed self-checking bench for cart_loader
module tb_cart_loader;
    localparam int AW = 8;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          cart_eject = 1'b0;
    logic [AW:0]   cart_size;
    logic [1:0]    cart_loaded;
    logic          overflow;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    cart_loader_if #(.ADDR_W(AW), .REGIONS(2)) bus ();

    cart_loader #(
        .ADDR_W(AW), .REGIONS(2), .INDEX_BASE(1), .CLEAR_FILL(1), .FILL_VALUE(8'hFF)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .io         (bus),
        .cart_eject (cart_eject),
        .cart_size  (cart_size),
        .cart_loaded(cart_loaded),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        step();
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        step();
    endtask

    task automatic send_byte(input string tag, input logic [24:0] a, input logic [7:0] d,
                             input bit exp_we, input logic exp_reg);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        step();
        bus.ioctl_wr = 1'b0;
        vectors++;
        if (exp_we) begin
            if ({bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_region} !== {1'b1, a[7:0], d, exp_reg}) begin
                miscompares++;
                $display("FAIL %s addr %0d: we/addr/din/reg got %b/%h/%h/%b expected 1/%h/%h/%b",
                         tag, a, bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_region, a[7:0], d, exp_reg);
            end
        end else if (bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL %s addr %0d: mem_we got %b expected 0", tag, a, bus.mem_we);
        end
    endtask

    task automatic wait_fill(input string tag, input int start, input int exp_n);
        int   ptr = start;
        int   nw = 0;
        int   nbad = 0;
        bit   done = 0;
        bit   last_ok = 0;
        logic prev_we = 1'b0;
        logic [7:0] prev_addr = 8'h00;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            if (busy === 1'b0) begin
                done = 1;
                last_ok = prev_we && (prev_addr == 8'hFF) && (bus.mem_we === 1'b0);
            end else if (bus.mem_we === 1'b1) begin
                nw++;
                if (bus.mem_addr !== ptr[7:0] || bus.mem_din !== 8'hFF) nbad++;
                ptr++;
            end
            prev_we   = bus.mem_we;
            prev_addr = bus.mem_addr;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s fill_timeout: busy still %b after 400 cycles, expected 0", tag, busy);
        end else begin
            vectors += 2;
            if (nw != exp_n || nbad != 0) begin
                miscompares++;
                $display("FAIL %s fill_writes: got %0d writes %0d bad expected %0d writes 0 bad", tag, nw, nbad, exp_n);
            end
            if (!last_ok) begin
                miscompares++;
                $display("FAIL %s busy_fall: last write addr %h we %b expected busy drop 1 cycle after write to ff",
                         tag, prev_addr, prev_we);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic [AW:0] exp_size,
                                input logic [1:0] exp_loaded, input logic exp_ovf);
        vectors++;
        if ({cart_size, cart_loaded, overflow} !== {exp_size, exp_loaded, exp_ovf}) begin
            miscompares++;
            $display("FAIL %s status: size/loaded/ovf got %0d/%b/%b expected %0d/%b/%b",
                     tag, cart_size, cart_loaded, overflow, exp_size, exp_loaded, exp_ovf);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_region, cart_size, cart_loaded, overflow, busy} !== '0) begin
            miscompares++;
            $display("FAIL %s zero_outputs: we %b addr %h din %h reg %b size %0d loaded %b ovf %b busy %b expected all 0",
                     tag, bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_region, cart_size, cart_loaded, overflow, busy);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
    endtask

    task automatic test_small_load_fill();
        start_dl(8'd1);
        for (int i = 0; i < 16; i++) send_byte("load16", 25'(i), 8'(i), 1'b1, 1'b0);
        end_dl();
        wait_fill("load16", 16, 240);
        check_status("load16", 9'd16, 2'b01, 1'b0);
    endtask

    task automatic test_overflow_load();
        start_dl(8'd2);
        for (int i = 0; i < 300; i++) send_byte("ovf300", 25'(i), 8'(i * 3), (i < 256), 1'b1);
        end_dl();
        vectors++;
        if (busy !== 1'b1 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf300 done_cycle: busy %b we %b expected busy 1 we 0", busy, bus.mem_we);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf300 no_fill: busy %b we %b expected busy 0 we 0", busy, bus.mem_we);
        end
        check_status("ovf300", 9'd256, 2'b11, 1'b1);
    endtask

    task automatic test_out_of_range();
        bit seen_busy = 0;
        start_dl(8'd5);
        seen_busy |= busy;
        for (int i = 0; i < 10; i++) begin
            send_byte("idx5", 25'(i), 8'hC0, 1'b0, 1'b0);
            seen_busy |= busy;
        end
        end_dl();
        seen_busy |= busy;
        step();
        seen_busy |= busy;
        vectors++;
        if (seen_busy) begin
            miscompares++;
            $display("FAIL idx5 busy: got 1 expected 0");
        end
        check_status("idx5", 9'd256, 2'b11, 1'b1);
    endtask

    task automatic test_eject();
        cart_eject = 1'b1;
        step();
        cart_eject = 1'b0;
        vectors++;
        if (cart_loaded !== 2'b00) begin
            miscompares++;
            $display("FAIL eject loaded: got %b expected 00", cart_loaded);
        end
    endtask

    task automatic test_wr_on_fall();
        start_dl(8'd1);
        for (int i = 0; i < 3; i++) send_byte("fallwr", 25'(i), 8'hA0 + 8'(i), 1'b1, 1'b0);
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 25'd3;
        bus.ioctl_dout     = 8'h5A;
        bus.ioctl_download = 1'b0;
        step();
        bus.ioctl_wr = 1'b0;
        vectors++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_din} !== {1'b1, 8'h03, 8'h5A}) begin
            miscompares++;
            $display("FAIL fallwr byte: we/addr/din got %b/%h/%h expected 1/03/5a", bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        wait_fill("fallwr", 4, 252);
        check_status("fallwr", 9'd4, 2'b01, 1'b0);
    endtask

    task automatic test_fill_abort();
        start_dl(8'd2);
        for (int i = 0; i < 8; i++) send_byte("abort_a", 25'(i), 8'h10 + 8'(i), 1'b1, 1'b1);
        end_dl();
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_region !== 1'b1) begin
            miscompares++;
            $display("FAIL abort mid_fill: busy %b we %b reg %b expected 1 1 1", busy, bus.mem_we, bus.mem_region);
        end
        start_dl(8'd1);
        vectors++;
        if (cart_loaded !== 2'b00 || bus.mem_we !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort restart: loaded %b we %b busy %b expected 00 0 1", cart_loaded, bus.mem_we, busy);
        end
        for (int i = 0; i < 5; i++) send_byte("abort_b", 25'(i), 8'h30 + 8'(i), 1'b1, 1'b0);
        end_dl();
        wait_fill("abort_b", 5, 251);
        check_status("abort_b", 9'd5, 2'b01, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        start_dl(8'd1);
        for (int i = 0; i < 7; i++) send_byte("rst_mid", 25'(i), 8'h70 + 8'(i), 1'b1, 1'b0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'd7;
        bus.ioctl_dout = 8'h77;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        check_all_zero("rst_held");
        reset              = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        step();
        start_dl(8'd2);
        for (int i = 0; i < 4; i++) send_byte("rst_after", 25'(i), 8'hE0 + 8'(i), 1'b1, 1'b1);
        end_dl();
        wait_fill("rst_after", 4, 252);
        check_status("rst_after", 9'd4, 2'b10, 1'b0);
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'h00;
        test_reset();
        test_small_load_fill();
        test_overflow_load();
        test_out_of_range();
        test_eject();
        test_wr_on_fall();
        test_fill_abort();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Parametrised cartridge image loader between the hps_io ioctl download stream and the system's cartridge block RAMs.
- Supports multiple cartridge regions, each selected by ioctl_index.
- Writes bytes with registered timing and tracks the loaded image size.
- Optionally pads the unused remainder of the region with a fill value, and holds the core in reset while busy.

Parameters:
- ADDR_W, 15: region address width; region depth DEPTH = 2^ADDR_W bytes.
- REGIONS, 2: number of cartridge regions (>= 2).
- INDEX_BASE, 1: ioctl_index of region 0; region r uses index INDEX_BASE+r.
- CLEAR_FILL, 1: 1 = pad addresses size..DEPTH-1 after the download; 0 = no padding.
- FILL_VALUE, 8'hFF: byte written during padding.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download-active level from hps_io.
- ioctl_index  in  8  download file index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address within the file.
- ioctl_dout  in  8  byte data.
- cart_eject  in  1  one-cycle pulse; clears all cart_loaded bits.
- mem_we  out  1  RAM write enable, one cycle per byte.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  8  RAM data.
- mem_region  out  $clog2(REGIONS)  target region select; valid while mem_we is high.
- cart_size  out  ADDR_W+1  byte count of the last completed or ongoing load.
- cart_loaded  out  REGIONS  per-region flag: region holds a valid image.
- overflow  out  1  last load contained addresses >= DEPTH.
- busy  out  1  high in LOAD, FILL and DONE; the top level ORs it into the core reset.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs are 0: mem_we, mem_addr, mem_din, mem_region, cart_size, cart_loaded, overflow, busy.
- Download edge detect: dl_q is a registered copy of ioctl_download. rise = ioctl_download & ~dl_q; fall = ~ioctl_download & dl_q.
- In range means INDEX_BASE <= ioctl_index < INDEX_BASE+REGIONS.
- IDLE:
  - rise with in-range index -> LOAD. Latch region = ioctl_index-INDEX_BASE. Clear cart_size, overflow and cart_loaded[region].
  - Out-of-range indices are ignored; state stays IDLE and nothing is written.
- LOAD:
  - ioctl_wr with ioctl_addr < DEPTH: on the next cycle mem_we=1, mem_addr=ioctl_addr[ADDR_W-1:0], mem_din=ioctl_dout, mem_region=region. Write latency is exactly 1 cycle.
  - On the same accepted write, cart_size <= max(cart_size, ioctl_addr+1).
  - ioctl_wr with ioctl_addr >= DEPTH: overflow <= 1, no write.
  - fall -> FILL if CLEAR_FILL=1 and cart_size < DEPTH; otherwise -> DONE.
  - ioctl_wr in the same cycle as fall is still accepted and written.
- FILL:
  - One write per cycle: mem_we=1, mem_din=FILL_VALUE.
  - Fill pointer starts at cart_size and increments through DEPTH-1, then -> DONE.
  - cart_size is not changed by fill.
  - rise with in-range index during FILL aborts the fill: go straight to LOAD for the new index, and the previous region's cart_loaded stays 0.
- DONE: one cycle. cart_loaded[region] <= (cart_size != 0). Then -> IDLE.
- mem_we is 0 in IDLE and DONE, and in LOAD on cycles with no accepted write.
- cart_eject clears all cart_loaded bits in any state. If it coincides with DONE, the DONE set wins for that region only.
- Size arithmetic uses ADDR_W+1 bits, so cart_size = DEPTH is representable.
- An empty download (rise then fall with no ioctl_wr): CLEAR_FILL=1 fills the whole region; cart_loaded stays 0.
- Reset mid-LOAD or mid-FILL: immediate return to IDLE, outputs 0, the partial write is dropped.

Test Plan (ADDR_W=8, REGIONS=2, INDEX_BASE=1, FILL_VALUE=8'hFF):
- Index 1, bytes 0x00..0x0F at addr 0..15, then fall -> 16 writes each exactly 1 cycle after ioctl_wr; then 240 FILL writes of 0xFF at addr 16..255; cart_size=16; cart_loaded=2'b01; busy falls 1 cycle after the last fill write.
- Index 2, 300 bytes -> addresses 0..255 written with mem_region=1; overflow=1; cart_size=256; no FILL cycles; cart_loaded[1]=1.
- Index 5 download of 10 bytes -> no mem_we, busy stays 0, cart_loaded unchanged.
- Index 1 re-download starting during FILL of a previous index-2 load -> FILL aborts; cart_loaded[1]=0; the new image is written to region 0.
- Assert reset mid-LOAD at byte 7 -> next cycle state IDLE and all outputs 0; a subsequent 4-byte load gives cart_size=4.
- cart_eject pulse with cart_loaded=2'b11 -> 2'b00 on the next edge; ioctl_wr coincident with fall -> that byte is written.
